// File: rtl/adder_serial_ctrl.sv
// Serial adder: one 2-bit slice per cycle, result after WIDTH/2 cycles, then held until Out_ready.
// One operation at a time; In_ready is low from accept until the result is consumed.
module adder_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic             Busy
);
    localparam int SLICES = WIDTH / 2;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_vld_q, out_vld_d;

    logic [2:0]       slice_t;
    logic [WIDTH-1:0] acc_next;
    logic             last_slice;

    always_comb begin
        slice_t    = {1'b0, a_sh_q[1:0]} + {1'b0, b_sh_q[1:0]} + {2'b00, carry_q};
        // New slice enters at the top so the LSB slice ends up at bit 0 after SLICES shifts.
        acc_next   = (acc_q >> 2) | (WIDTH'(slice_t[1:0]) << (WIDTH - 2));
        last_slice = (cnt_q == CW'(SLICES - 1));

        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        out_vld_d = out_vld_q;

        case (state_q)
            IDLE: begin
                if (In_valid) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_next;
                carry_d = slice_t[2];
                a_sh_d  = a_sh_q >> 2;
                b_sh_d  = b_sh_q >> 2;
                cnt_d   = cnt_q + CW'(1);
                if (last_slice) begin
                    sum_d     = acc_next;
                    cout_d    = slice_t[2];
                    out_vld_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (Out_ready) begin
                    out_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign In_ready  = (state_q == IDLE) & ~Reset;
    assign Busy      = (state_q != IDLE);
    assign Sum       = sum_q;
    assign Carry     = cout_q;
    assign Out_valid = out_vld_q;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Directed and table-driven checks of the serial adder at WIDTH=8, 2 and 16.
module tb_adder_serial_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        cin8 = 0, iv8 = 0, ir8, c8, ov8, or8 = 0, bz8;
    logic [1:0]  a2 = '0, b2 = '0, s2;
    logic        cin2 = 0, iv2 = 0, ir2, c2, ov2, or2 = 0, bz2;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        cin16 = 0, iv16 = 0, ir16, c16, ov16, or16 = 0, bz16;

    adder_serial_ctrl #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .A(a8), .B(b8), .Cin(cin8), .In_valid(iv8), .In_ready(ir8),
        .Sum(s8), .Carry(c8), .Out_valid(ov8), .Out_ready(or8), .Busy(bz8));
    adder_serial_ctrl #(.WIDTH(2)) dut2 (
        .Clk(clk), .Reset(rst), .A(a2), .B(b2), .Cin(cin2), .In_valid(iv2), .In_ready(ir2),
        .Sum(s2), .Carry(c2), .Out_valid(ov2), .Out_ready(or2), .Busy(bz2));
    adder_serial_ctrl #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst), .A(a16), .B(b16), .Cin(cin16), .In_valid(iv16), .In_ready(ir16),
        .Sum(s16), .Carry(c16), .Out_valid(ov16), .Out_ready(or16), .Busy(bz16));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic get_rdy(input int w);
        return (w == 2) ? ir2 : (w == 8) ? ir8 : ir16;
    endfunction
    function automatic logic get_ovld(input int w);
        return (w == 2) ? ov2 : (w == 8) ? ov8 : ov16;
    endfunction
    function automatic logic [15:0] get_sum(input int w);
        return (w == 2) ? {14'd0, s2} : (w == 8) ? {8'd0, s8} : s16;
    endfunction
    function automatic logic get_carry(input int w);
        return (w == 2) ? c2 : (w == 8) ? c8 : c16;
    endfunction

    task automatic set_in(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic ci);
        case (w)
            2:       begin iv2 = v;  a2 = a[1:0];  b2 = b[1:0];  cin2 = ci;  end
            8:       begin iv8 = v;  a8 = a[7:0];  b8 = b[7:0];  cin8 = ci;  end
            default: begin iv16 = v; a16 = a;      b16 = b;      cin16 = ci; end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic r);
        case (w)
            2:       or2 = r;
            8:       or8 = r;
            default: or16 = r;
        endcase
    endtask

    // Accept one operation, return the result and the edges from accept to Out_valid.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic ci,
                          output logic [15:0] s, output logic c, output int lat);
        int n;
        @(negedge clk);
        set_in(w, 1'b1, a, b, ci);
        n = 0;
        while (!get_rdy(w) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        set_in(w, 1'b0, 16'h0, 16'h0, 1'b0);
        lat = 0;
        while (!get_ovld(w) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        s = get_sum(w);
        c = get_carry(w);
    endtask

    task automatic pop(input int w);
        set_ordy(w, 1'b1);
        @(negedge clk);
        set_ordy(w, 1'b0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_carry;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [15:0] s;
        logic        c;
        int          lat;
        int          acc_t[$];
        logic        seen;
        logic [16:0] ref_sum;
        logic [15:0] ra, rb;
        logic        rc;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        // Reset held for two edges
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_sum", 32'(s8), 32'd0);
        check("rst_carry", 32'(c8), 32'd0);
        check("rst_in_ready", 32'(ir8), 32'd0);
        check("rst_busy", 32'(bz8), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(ir8), 32'd1);
        check("post_rst_busy", 32'(bz8), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(8, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, vecs[i].cin, s, c, lat);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].exp_carry));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            pop(8);
        end

        // Backpressure: result held, new operands ignored
        run_op(8, 16'h00C3, 16'h001E, 1'b1, s, c, lat);
        check("bp_sum", 32'(s), 32'h0E2);
        for (int i = 0; i < 5; i++) begin
            set_in(8, 1'b1, 16'($urandom), 16'($urandom), 1'b1);
            @(negedge clk);
            check("bp_out_valid", 32'(ov8), 32'd1);
            check("bp_sum_hold", 32'(s8), 32'h0E2);
            check("bp_carry_hold", 32'(c8), 32'd0);
            check("bp_in_ready", 32'(ir8), 32'd0);
        end
        set_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
        pop(8);
        check("after_pop_valid", 32'(ov8), 32'd0);
        check("after_pop_sum", 32'(s8), 32'h0E2);
        check("after_pop_in_ready", 32'(ir8), 32'd1);

        // Back-to-back with both handshakes held high
        set_ordy(8, 1'b1);
        set_in(8, 1'b1, 16'h0011, 16'h0022, 1'b0);
        for (int n = 0; n < 40 && acc_t.size() < 3; n++) begin
            if (ir8) acc_t.push_back(cyc);
            @(negedge clk);
        end
        check("b2b_accepts", 32'(acc_t.size()), 32'd3);
        if (acc_t.size() == 3) begin
            check("b2b_gap0", 32'(acc_t[1] - acc_t[0]), 32'd6);
            check("b2b_gap1", 32'(acc_t[2] - acc_t[1]), 32'd6);
        end
        set_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (8) @(negedge clk);
        set_ordy(8, 1'b0);
        check("b2b_sum", 32'(s8), 32'h033);
        check("b2b_idle", 32'(bz8), 32'd0);

        // Reset during the second RUN cycle abandons the operation
        set_in(8, 1'b1, 16'h0012, 16'h0034, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
        check("mid_busy", 32'(bz8), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_sum", 32'(s8), 32'd0);
        check("mid_rst_busy", 32'(bz8), 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            seen = seen | ov8;
            @(negedge clk);
        end
        check("mid_rst_no_valid", 32'(seen), 32'd0);
        run_op(8, 16'h0012, 16'h0034, 1'b0, s, c, lat);
        check("mid_rerun_sum", 32'(s), 32'h046);
        check("mid_rerun_carry", 32'(c), 32'd0);
        pop(8);

        // WIDTH=2
        run_op(2, 16'd3, 16'd3, 1'b1, s, c, lat);
        check("w2_sum", 32'(s), 32'd3);
        check("w2_carry", 32'(c), 32'd1);
        check("w2_latency", 32'(lat), 32'd1);
        pop(2);
        run_op(2, 16'd2, 16'd1, 1'b0, s, c, lat);
        check("w2b_sum", 32'(s), 32'd3);
        check("w2b_carry", 32'(c), 32'd0);
        pop(2);

        // Random WIDTH=8 and WIDTH=16 against A+B+Cin
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            run_op(16, ra, rb, rc, s, c, lat);
            check("w16_result", 32'({c, s}), 32'(ref_sum));
            check("w16_latency", 32'(lat), 32'd8);
            pop(16);
            ref_sum = {9'd0, ra[7:0]} + {9'd0, rb[7:0]} + {16'd0, rc};
            run_op(8, ra, rb, rc, s, c, lat);
            check("w8_result", 32'({c, s[7:0]}), 32'(ref_sum[8:0]));
            pop(8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
